// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the uart_tx_scheduler slice: FSM states and sizing helpers.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUSY = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int TIMEOUT_CYCLES = 4;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and uart_tx side signals of the scheduler, bundled for port passing.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [7:0]           uart_byte_o;
    logic                 uart_transmit_o;
    logic                 uart_busy_i;
    logic                 uart_err_i;
    logic                 busy_o;
    logic                 fault_o;

    modport master (
        input  req_valid_i, req_data_i, req_last_i, uart_busy_i, uart_err_i,
        output req_ready_o, grant_o, uart_byte_o, uart_transmit_o, busy_o, fault_o
    );

    modport slave (
        output req_valid_i, req_data_i, req_last_i, uart_busy_i, uart_err_i,
        input  req_ready_o, grant_o, uart_byte_o, uart_transmit_o, busy_o, fault_o
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module uart_tx_scheduler_rr_pick
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = ptr_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int j;
        j    = 0;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && valid[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among NUM_REQ byte streams with round-robin message grants,
// a full stop-bit gap between bytes, a busy timeout and a sticky fault trap.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CLK_CYCLES = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int MAX_BURST  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    uart_tx_scheduler_if.master bus
);

    localparam int GAP_CYCLES = CLK_CYCLES / BAUD_RATE;
    localparam int IW = ptr_bits(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [BW-1:0]      burst;
    logic [GW-1:0]      gap;
    logic [TW-1:0]      tmo;
    logic               last_q;

    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [7:0]         pick_data;
    logic               pick_last;
    logic [7:0]         own_data;
    logic               own_last;
    logic               own_valid;
    logic               release_now;
    logic [IW-1:0]      next_ptr;

    uart_tx_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid (bus.req_valid_i),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_data = bus.req_data_i[{pick_idx, 3'b000} +: 8];
    assign pick_last = bus.req_last_i[pick_idx];
    assign own_data  = bus.req_data_i[{owner, 3'b000} +: 8];
    assign own_last  = bus.req_last_i[owner];
    assign own_valid = bus.req_valid_i[owner];
    assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    assign release_now = last_q || (burst == BW'(MAX_BURST)) || !own_valid;

    // uart_err_i and the FAULT state both pre-empt every other transition.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state               <= ST_IDLE;
            ptr                 <= '0;
            owner               <= '0;
            burst               <= '0;
            gap                 <= '0;
            tmo                 <= '0;
            last_q              <= 1'b0;
            bus.grant_o         <= '0;
            bus.req_ready_o     <= '0;
            bus.uart_byte_o     <= '0;
            bus.uart_transmit_o <= 1'b0;
            bus.busy_o          <= 1'b0;
            bus.fault_o         <= 1'b0;
        end else if (bus.uart_err_i || state == ST_FAULT) begin
            state               <= ST_FAULT;
            bus.grant_o         <= '0;
            bus.req_ready_o     <= '0;
            bus.uart_transmit_o <= 1'b0;
            bus.busy_o          <= 1'b0;
            bus.fault_o         <= 1'b1;
        end else begin
            bus.uart_transmit_o <= 1'b0;
            bus.req_ready_o     <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (!bus.uart_busy_i && pick_any) begin
                        owner               <= pick_idx;
                        bus.grant_o         <= pick;
                        bus.req_ready_o     <= pick;
                        bus.uart_byte_o     <= pick_data;
                        bus.uart_transmit_o <= 1'b1;
                        bus.busy_o          <= 1'b1;
                        last_q              <= pick_last;
                        burst               <= BW'(1);
                        tmo                 <= '0;
                        state               <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (bus.uart_busy_i) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.grant_o <= '0;
                        bus.busy_o  <= 1'b0;
                        bus.fault_o <= 1'b1;
                        state       <= ST_FAULT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.uart_busy_i) begin
                        gap   <= GW'(GAP_CYCLES - 1);
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap != '0) begin
                        gap <= gap - 1'b1;
                    end else if (release_now) begin
                        bus.grant_o <= '0;
                        bus.busy_o  <= 1'b0;
                        ptr         <= next_ptr;
                        burst       <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        bus.req_ready_o     <= bus.grant_o;
                        bus.uart_byte_o     <= own_data;
                        bus.uart_transmit_o <= 1'b1;
                        last_q              <= own_last;
                        burst               <= burst + 1'b1;
                        tmo                 <= '0;
                        state               <= ST_WAIT_BUSY;
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural uart_tx busy model.
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int FRAME = 20;

    typedef struct {
        int         req;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stuck = 1'b0;
    int   cnt = 0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fall_cyc = -100;
    logic prev_busy = 1'b0;
    logic [N-1:0] prev_grant = '0;
    exp_t e;

    exp_t       exp_q[$];
    logic [8:0] rq[N][$];

    uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ    (N),
        .CLK_CYCLES (1_000_000),
        .BAUD_RATE  (100_000),
        .MAX_BURST  (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the cycle after a transmit pulse.
    always @(posedge clk) begin
        if (bus.uart_transmit_o && !stuck) cnt <= FRAME;
        else if (cnt != 0) cnt <= cnt - 1;
    end
    assign bus.uart_busy_i = (cnt != 0);

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (bus.req_ready_o[k] && rq[k].size() != 0) void'(rq[k].pop_front());
            if (rq[k].size() != 0) begin
                bus.req_valid_i[k]       = 1'b1;
                bus.req_data_i[8*k +: 8] = rq[k][0][7:0];
                bus.req_last_i[k]        = rq[k][0][8];
            end else begin
                bus.req_valid_i[k]       = 1'b0;
                bus.req_data_i[8*k +: 8] = 8'h00;
                bus.req_last_i[k]        = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (prev_busy && !bus.uart_busy_i) fall_cyc = cyc;
        if (bus.uart_transmit_o) begin
            total++;
            if (bus.uart_busy_i) begin
                bad++;
                $display("FAIL tx_while_busy: busy=%0b required 0", bus.uart_busy_i);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx: byte=%h grant=%b required none", bus.uart_byte_o, bus.grant_o);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (bus.grant_o != N'(1 << e.req) || bus.req_ready_o != N'(1 << e.req)
                    || bus.uart_byte_o != e.b) begin
                    bad++;
                    $display("FAIL tx_byte: grant=%b ready=%b byte=%h required req%0d byte=%h",
                             bus.grant_o, bus.req_ready_o, bus.uart_byte_o, e.req, e.b);
                end
            end
            if (prev_grant != '0) begin
                total++;
                if (cyc - fall_cyc < 10) begin
                    bad++;
                    $display("FAIL stop_gap: gap=%0d required >=10", cyc - fall_cyc);
                end
            end
        end else if (bus.req_ready_o != '0) begin
            total++;
            bad++;
            $display("FAIL ready_no_tx: ready=%b required 0", bus.req_ready_o);
        end
        prev_busy  = bus.uart_busy_i;
        prev_grant = bus.grant_o;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic last, input logic want);
        rq[k].push_back({last, b});
        if (want) exp_q.push_back('{k, b});
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.uart_transmit_o && n < 500);
        if (!bus.uart_transmit_o) n = -1;
    endtask

    task automatic wait_busy(input logic lvl);
        int n = 0;
        while (bus.uart_busy_i != lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_wait", int'(bus.uart_busy_i), int'(lvl));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy_o || bus.grant_o != '0 || bus.uart_busy_i)
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 2000), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic at_post();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.uart_err_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(bus.grant_o), 0);
        chk("rst_ready", int'(bus.req_ready_o), 0);
        chk("rst_tx", int'(bus.uart_transmit_o), 0);
        chk("rst_byte", int'(bus.uart_byte_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_fault", int'(bus.fault_o), 0);
        rst_n = 1'b1;

        at_post();
        push(0, 8'hA5, 1'b1, 1'b1);
        wait_tx(n);
        chk("t1_latency", n, 2);
        wait_busy(1'b1);
        wait_busy(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant_o != '0 && n < 50);
        chk("t1_release", n, 11);
        wait_idle();

        at_post();
        push(1, 8'h01, 1'b1, 1'b1);
        push(2, 8'h02, 1'b1, 1'b1);
        wait_idle();
        at_post();
        push(0, 8'h03, 1'b1, 1'b1);
        push(1, 8'h04, 1'b1, 1'b1);
        wait_idle();

        at_post();
        push(0, 8'h11, 1'b0, 1'b1);
        push(0, 8'h22, 1'b0, 1'b1);
        push(0, 8'h33, 1'b1, 1'b1);
        wait_tx(n);
        at_post();
        push(3, 8'h44, 1'b1, 1'b1);
        wait_idle();

        at_post();
        for (int i = 0; i < 5; i++) push(0, 8'h50 + 8'(i), 1'b0, 1'b0);
        push(1, 8'h61, 1'b1, 1'b0);
        exp_q.push_back('{0, 8'h50});
        exp_q.push_back('{0, 8'h51});
        exp_q.push_back('{0, 8'h52});
        exp_q.push_back('{1, 8'h61});
        exp_q.push_back('{0, 8'h53});
        exp_q.push_back('{0, 8'h54});
        wait_idle();

        at_post();
        push(2, 8'h77, 1'b1, 1'b1);
        wait_tx(n);
        wait_busy(1'b1);
        @(negedge clk);
        bus.uart_err_i = 1'b1;
        @(negedge clk);
        chk("t5_fault", int'(bus.fault_o), 1);
        chk("t5_busy", int'(bus.busy_o), 0);
        chk("t5_grant", int'(bus.grant_o), 0);
        bus.uart_err_i = 1'b0;
        at_post();
        push(1, 8'h88, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        chk("t5_sticky", int'(bus.fault_o), 1);
        chk("t5_unserved", rq[1].size(), 1);
        at_post();
        for (int k = 0; k < N; k++) rq[k].delete();
        do_reset();
        chk("t5_cleared", int'(bus.fault_o), 0);
        wait_idle();

        stuck = 1'b1;
        at_post();
        push(3, 8'h3C, 1'b1, 1'b1);
        wait_tx(n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fault_o && n < 20);
        chk("t6_timeout", n, 4);
        stuck = 1'b0;
        do_reset();
        wait_idle();

        at_post();
        push(2, 8'h5A, 1'b1, 1'b1);
        wait_tx(n);
        wait_busy(1'b1);
        at_post();
        push(1, 8'h66, 1'b1, 1'b1);
        do_reset();
        chk("t6_midframe_busy", int'(bus.uart_busy_i), 1);
        wait_idle();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
